sync_ram_sequence_reader: RTL and testbench

//   Read-side controller for the 16x4 synchronous sequence RAM (registered address, 1-cycle read).
//   On start, walks addresses 0..limite in order, fetches each 4-bit entry and hands it to the

---
 rtl/sync_ram_sequence_reader.sv | 95 +++++++++
 tb/tb_sync_ram_sequence_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_sequence_reader.sv
// Read-side sequencer for a small synchronous RAM: walks addresses 0..limite,
// presents each word over valid/ready and pulses done once the last word is accepted.
module sync_ram_sequence_reader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] limite,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] dado,
    output logic              dado_valid,
    input  logic              dado_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapture,
        StPresent,
        StDone
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] limite_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            counter    <= '0;
            limite_reg <= '0;
            dado       <= '0;
            dado_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            // Abort outranks every other transition; it never produces a done pulse.
            if (abort && (state != StIdle)) begin
                state      <= StIdle;
                dado_valid <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start && !abort) begin
                            counter    <= '0;
                            limite_reg <= limite;
                            state      <= StFetch;
                        end
                    end
                    StFetch: begin
                        state <= StCapture;
                    end
                    StCapture: begin
                        dado       <= ram_q;
                        dado_valid <= 1'b1;
                        state      <= StPresent;
                    end
                    StPresent: begin
                        if (dado_ready) begin
                            dado_valid <= 1'b0;
                            // Compare before incrementing so a full-depth run never wraps to 0.
                            if (counter == limite_reg) begin
                                done  <= 1'b1;
                                state <= StDone;
                            end else begin
                                counter <= counter + 1'b1;
                                state   <= StFetch;
                            end
                        end
                    end
                    StDone: begin
                        state <= StIdle;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign busy     = (state == StFetch) || (state == StCapture) || (state == StPresent);
    assign ram_addr = counter;
    assign ram_we   = 1'b0;
    assign ram_data = '0;

endmodule

// File: tb/tb_sync_ram_sequence_reader.sv
// Scoreboard bench for sync_ram_sequence_reader with a behavioural 16x4 synchronous RAM.
module tb_sync_ram_sequence_reader;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              dado_ready = 1'b1;
    logic [ADDR_W-1:0] limite = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] dado;
    logic              dado_valid;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [16];
    logic [DATA_W-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail = 0;
    int done_count = 0;

    sync_ram_sequence_reader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .limite    (limite),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_data  (ram_data),
        .ram_q     (ram_q),
        .dado      (dado),
        .dado_valid(dado_valid),
        .dado_ready(dado_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Registered-address RAM: word for the address seen at an edge is readable after it.
    always @(posedge clk) ram_q <= mem[ram_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Handshake values are stable here; an accept happens at the following rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            check_eq("ram_we", ram_we, 0);
            check_eq("ram_data", ram_data, 0);
            if (done) begin
                done_count++;
                check_eq("done_with_valid", dado_valid, 0);
            end
            if (dado_valid) begin
                if (exp_q.size() == 0) check_eq("extra_entry", dado_valid, 0);
                else if (dado_ready) check_eq("dado", dado, exp_q.pop_front());
                else check_eq("dado_hold", dado, exp_q[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int lim);
        for (int a = 0; a <= lim; a++) exp_q.push_back(mem[a]);
        limite = ADDR_W'(lim);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check_eq("done_seen", done, 1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!dado_valid && n < budget) begin
            tick();
            n++;
        end
        check_eq("valid_seen", dado_valid, 1);
    endtask

    initial begin
        int n;
        int dc;
        mem = '{4'h0, 4'hA, 4'h2, 4'h4, 4'h7, 4'h1, 4'hC, 4'h3,
                4'h9, 4'hE, 4'h6, 4'hB, 4'h8, 4'hD, 4'hF, 4'h5};

        // Reset state
        #1 reset = 1'b1;
        #1;
        check_eq("rst_dado", dado, 0);
        check_eq("rst_valid", dado_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_addr", ram_addr, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // limite=3, ready high: latency, throughput, start ignored in DONE
        start_run(3);
        check_eq("busy_after_start", busy, 1);
        check_eq("valid_n0", dado_valid, 0);
        tick();
        check_eq("valid_n1", dado_valid, 0);
        tick();
        check_eq("valid_n2", dado_valid, 1);
        wait_done(40, n);
        check_eq("done_latency_l3", n + 2, 12);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("done_pulse_width", done, 0);
        check_eq("no_restart_from_done", busy, 0);
        check_eq("sb_empty_l3", exp_q.size(), 0);
        check_eq("done_count_l3", done_count, 1);

        // limite=1 with a 5-cycle stall on the first entry
        dado_ready = 1'b0;
        start_run(1);
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", dado_valid, 1);
            check_eq("stall_dado", dado, 0);
            tick();
        end
        dado_ready = 1'b1;
        tick();
        wait_done(10, n);
        check_eq("done_after_accept2", n, 3);
        tick();
        check_eq("done_pulse_l1", done, 0);
        check_eq("idle_after_l1", busy, 0);
        check_eq("sb_empty_l1", exp_q.size(), 0);

        // limite=0: exactly one entry
        start_run(0);
        wait_done(20, n);
        check_eq("done_latency_l0", n, 3);
        tick();
        check_eq("sb_empty_l0", exp_q.size(), 0);

        // limite=15 full depth; start and a new limite while busy must be ignored
        start_run(15);
        limite = 4'd2;
        start  = 1'b1;
        repeat (6) tick();
        start  = 1'b0;
        wait_done(60, n);
        check_eq("done_latency_l15", n + 6, 48);
        tick();
        repeat (4) tick();
        check_eq("no_17th_entry", dado_valid, 0);
        check_eq("sb_empty_l15", exp_q.size(), 0);
        check_eq("done_count_l15", done_count, 4);

        // abort while presenting address 2
        dado_ready = 1'b0;
        start_run(5);
        wait_valid(10);
        dado_ready = 1'b1;
        tick();
        dado_ready = 1'b0;
        wait_valid(10);
        dado_ready = 1'b1;
        tick();
        dado_ready = 1'b0;
        wait_valid(10);
        check_eq("abort_pre_dado", dado, mem[2]);
        dc = done_count;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        check_eq("abort_valid", dado_valid, 0);
        check_eq("abort_busy", busy, 0);
        repeat (5) tick();
        check_eq("abort_no_done", done_count, dc);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("start_abort_idle", busy, 0);

        // restart after abort begins at address 0
        dado_ready = 1'b1;
        start_run(2);
        wait_done(20, n);
        check_eq("done_latency_l2", n, 9);
        tick();
        check_eq("sb_empty_l2", exp_q.size(), 0);

        // async reset between edges during CAPTURE
        start_run(3);
        tick();
        #2 reset = 1'b1;
        #1;
        check_eq("arst_dado", dado, 0);
        check_eq("arst_valid", dado_valid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_addr", ram_addr, 0);
        exp_q.delete();
        dc = done_count;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) tick();
        check_eq("arst_idle", busy, 0);
        check_eq("arst_no_done", done_count, dc);
        start_run(3);
        wait_done(40, n);
        check_eq("done_latency_post_rst", n, 12);
        tick();
        check_eq("sb_empty_post_rst", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
